// File: rtl/wb_regfile.sv
// wb_regfile: write-back select plus 32 x 32-bit general-purpose register file.
// Register 0 is hardwired to zero. Two combinational read ports feed ID, and a
// committed-write counter is kept for debug/performance checks.
// Optional feature macro: WB_REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              WB_reg_write,
  input  logic              WB_mem_to_reg,
  input  logic [DATA_W-1:0] WB_mem_data,
  input  logic [DATA_W-1:0] WB_alu_result,
  input  logic [ADDR_W-1:0] WB_mux_out,
  input  logic [ADDR_W-1:0] ID_rs,
  input  logic [ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0] ID_read_data1,
  output logic [DATA_W-1:0] ID_read_data2,
  output logic [DATA_W-1:0] WB_write_data,
  output logic [31:0]       WB_commit_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [31:0]       r_commit_count;
  logic [DATA_W-1:0] w_write_data;
  logic              w_commit;
  logic [DATA_W-1:0] w_read_data1;
  logic [DATA_W-1:0] w_read_data2;

  // Write-back source select and commit qualification (index 0 never commits).
  always_comb begin
    w_write_data = WB_alu_result;
    w_commit     = 1'b0;
    if (WB_mem_to_reg) begin
      w_write_data = WB_mem_data;
    end else begin
      w_write_data = WB_alu_result;
    end
    if (WB_reg_write && (WB_mux_out != {ADDR_W{1'b0}})) begin
      w_commit = 1'b1;
    end else begin
      w_commit = 1'b0;
    end
  end

  // Register array update: reset clears everything and beats a simultaneous commit.
  always_ff @(posedge clk) begin
    if (startin) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_commit) begin
      r_regs[WB_mux_out] <= w_write_data;
    end
  end

  // Commit counter: one increment per committing edge, free-running wrap.
  always_ff @(posedge clk) begin
    if (startin) begin
      r_commit_count <= 32'd0;
    end else if (w_commit) begin
      r_commit_count <= r_commit_count + 32'd1;
    end
  end

  // Read port 1: index 0 reads zero; optional bypass of the in-flight write.
  always_comb begin
    w_read_data1 = {DATA_W{1'b0}};
    if (ID_rs == {ADDR_W{1'b0}}) begin
      w_read_data1 = {DATA_W{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
    end else if (w_commit && (ID_rs == WB_mux_out)) begin
      w_read_data1 = w_write_data;
`endif
    end else begin
      w_read_data1 = r_regs[ID_rs];
    end
  end

  // Read port 2: same rules as port 1, independent index.
  always_comb begin
    w_read_data2 = {DATA_W{1'b0}};
    if (ID_rt == {ADDR_W{1'b0}}) begin
      w_read_data2 = {DATA_W{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
    end else if (w_commit && (ID_rt == WB_mux_out)) begin
      w_read_data2 = w_write_data;
`endif
    end else begin
      w_read_data2 = r_regs[ID_rt];
    end
  end

  assign ID_read_data1   = w_read_data1;
  assign ID_read_data2   = w_read_data2;
  assign WB_write_data   = w_write_data;
  assign WB_commit_count = r_commit_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vectors, a behavioural model of
// the register file checked every cycle, plus literal expectations.
module tb_wb_regfile;

  logic        clk;
  logic        startin;
  logic        WB_reg_write;
  logic        WB_mem_to_reg;
  logic [31:0] WB_mem_data;
  logic [31:0] WB_alu_result;
  logic [4:0]  WB_mux_out;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic [31:0] ID_read_data1;
  logic [31:0] ID_read_data2;
  logic [31:0] WB_write_data;
  logic [31:0] WB_commit_count;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .startin(startin), .WB_reg_write(WB_reg_write),
    .WB_mem_to_reg(WB_mem_to_reg), .WB_mem_data(WB_mem_data),
    .WB_alu_result(WB_alu_result), .WB_mux_out(WB_mux_out),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_read_data1(ID_read_data1),
    .ID_read_data2(ID_read_data2), .WB_write_data(WB_write_data),
    .WB_commit_count(WB_commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: value the write-back stage selects.
  function automatic logic [31:0] m_wdata();
    return WB_mem_to_reg ? WB_mem_data : WB_alu_result;
  endfunction

  // Model: value a read port must show for the given index right now.
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && WB_reg_write && WB_mux_out == idx) return m_wdata();
    return m_regs[idx];
  endfunction

  // Model update at each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (startin) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;
    end else if (WB_reg_write && WB_mux_out != 5'd0) begin
      m_regs[WB_mux_out] = m_wdata();
      m_count = m_count + 32'd1;
    end
  end

  // Per-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_rd1",   ID_read_data1,   m_read(ID_rs));
      chk("cyc_rd2",   ID_read_data2,   m_read(ID_rt));
      chk("cyc_wdata", WB_write_data,   m_wdata());
      chk("cyc_count", WB_commit_count, m_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic we, input logic m2r,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    startin = rst; WB_reg_write = we; WB_mem_to_reg = m2r;
    WB_mem_data = mem; WB_alu_result = alu; WB_mux_out = dst;
    ID_rs = rs; ID_rt = rt;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick();
    check_en = 1'b1;

    // Fill r5 then reset it away.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h12345678, 5'd5, 5'd5, 5'd5);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    #2;
    chk("fill_r5", ID_read_data1, 32'h12345678);
    chk("fill_cnt", WB_commit_count, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    #2;
    chk("reset_r5", ID_read_data1, 32'd0);
    chk("reset_cnt", WB_commit_count, 32'd0);

    // ALU write-back to r25.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hAABBCCDD, 5'd25, 5'd0, 5'd25);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd25);
    #2;
    chk("alu_r25", ID_read_data2, 32'hAABBCCDD);
    chk("alu_cnt", WB_commit_count, 32'd1);

    // Load write-back to r21, then a non-committing cycle targeting r21.
    drive(1'b0, 1'b1, 1'b1, 32'h22222222, 32'h99999999, 5'd21, 5'd0, 5'd0);
    #2;
    chk("load_wdata", WB_write_data, 32'h22222222);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h33333333, 5'd21, 5'd21, 5'd25);
    #2;
    chk("load_r21", ID_read_data1, 32'h22222222);
    chk("nowr_wdata", WB_write_data, 32'h33333333);
    tick();
    #2;
    chk("nowr_r21", ID_read_data1, 32'h22222222);
    chk("nowr_cnt", WB_commit_count, 32'd2);

    // Commit to register 0 is discarded.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    #2;
    chk("zero_pre", ID_read_data1, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #2;
    chk("zero_rd", ID_read_data1, 32'd0);
    chk("zero_cnt", WB_commit_count, 32'd2);

    // Bypass behaviour on r13.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h11111111, 5'd13, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hCCDDEEFF, 5'd13, 5'd13, 5'd13);
    #2;
    chk("byp_rd1", ID_read_data1, BYPASS ? 32'hCCDDEEFF : 32'h11111111);
    chk("byp_rd2", ID_read_data2, BYPASS ? 32'hCCDDEEFF : 32'h11111111);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd13, 5'd13);
    #2;
    chk("byp_post", ID_read_data1, 32'hCCDDEEFF);
    chk("byp_cnt", WB_commit_count, 32'd4);

    // A few more writes across the index range, including the top index.
    drive(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd31, 5'd31, 5'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h00000001, 5'd1, 5'd31, 5'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h80000000, 5'd31, 5'd1, 5'd31);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h5A5A5A5A, 32'h0, 5'd7, 5'd31, 5'd1);
    #2;
    chk("misc_r31", ID_read_data1, 32'h80000000);
    chk("misc_r1", ID_read_data2, 32'h00000001);
    chk("misc_cnt", WB_commit_count, 32'd7);
    tick();

    // Reset beats a simultaneous commit.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h00000005, 5'd3, 5'd3, 5'd31);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd31);
    #2;
    chk("rstwin_r3", ID_read_data1, 32'd0);
    chk("rstwin_r31", ID_read_data2, 32'd0);
    chk("rstwin_cnt", WB_commit_count, 32'd0);
    tick();
    tick();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
